redmule_tcdm_responder: RTL
===========================

Name: redmule_tcdm_responder

Overview:
Wide-port TCDM memory responder: the memory end of the RedMulE data port protocol (req/wen/be/add/data/lrdy/user in; gnt/r_valid/r_data/r_opc/r_user out). It serves one DATA_W-bit initiator from an internal word-interleaved array of 32-bit words, with fixed read latency, grant back-pressure and a response FIFO honouring lrdy. It is used as the TCDM model in accelerator-level testbenches and as a scratchpad in standalone integrations.

Parameters:
DATA_W, 288, port width in bits; multiple of 32; NW = DATA_W/32 words per access
ADDR_W, 32, byte-address width
MEM_WORDS, 4096, depth in 32-bit words; power of two, >= NW
BASE_ADDR, 32'h0, byte address mapped to word 0
LATENCY, 1, grant-to-r_valid cycles for reads; legal range 1..4
FIFO_DEPTH, LATENCY+1, response FIFO entries; also the read-credit limit

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_i  in  1  request valid
wen_i  in  1  1 = read, 0 = write
be_i  in  DATA_W/8  byte enables for writes
add_i  in  ADDR_W  byte address of the first 32-bit word
data_i  in  DATA_W  write data; word k sits at bits [32k+31:32k]
lrdy_i  in  1  initiator ready for a response
user_i  in  1  sideband, echoed on the response
stall_i  in  1  testbench/arbiter-forced grant denial
gnt_o  out  1  request accepted this cycle
r_valid_o  out  1  read response valid
r_data_o  out  DATA_W  read data
r_opc_o  out  1  response error: request address misaligned
r_user_o  out  1  echoed user_i
outstanding_o  out  $clog2(FIFO_DEPTH)+1  reads in the pipeline plus reads in the FIFO

Behaviour:
- Address map: widx = ((add_i - BASE_ADDR) >> 2) mod MEM_WORDS. An access touches words widx+k (k = 0..NW-1), each taken mod MEM_WORDS, so accesses wrap at the top of the array.
- Misalignment (add_i[1:0] != 0): the access proceeds as if aligned down and is flagged.
  - Reads: r_opc_o = 1 on that response.
  - Writes: the flag is dropped; no response exists.
- Grant rule (combinational): gnt_o = req_i & ~stall_i & (wen_i ? outstanding < FIFO_DEPTH : 1).
  - A pop in the same cycle does not free a credit (conservative).
  - Requests are neither queued nor latched; the initiator holds req_i until gnt_o.
- Write: on the rising edge ending the grant cycle, byte b of data_i is written iff be_i[b] = 1. Byte b maps to word widx + b/4, byte lane b%4. Writes produce no response.
- Read:
  - Memory is sampled on the edge ending the grant cycle (t) into pipeline stage 1, together with user_i and the misalign flag.
  - The data then moves through LATENCY-1 further stages and is pushed into the FIFO.
  - Push occurs on the edge ending cycle t+LATENCY-1, so r_valid_o can first be 1 in cycle t+LATENCY.
- Back-to-back ordering: a read granted in the cycle after a write to the same words returns the new data. Responses return in grant order.
- Response output:
  - r_valid_o = FIFO not empty; r_data_o, r_opc_o and r_user_o come from the FIFO head.
  - Pop occurs when r_valid_o & lrdy_i.
  - While lrdy_i = 0, the head and all response outputs hold stable.
- Credit: outstanding_o increments on each read grant and decrements on each pop. A simultaneous grant and pop leaves it unchanged. It can never exceed FIFO_DEPTH, so the FIFO cannot overflow.
- Reset (synchronous, including mid-operation):
  - Pipeline valids, FIFO pointers and outstanding_o are cleared.
  - r_valid_o, r_opc_o, r_user_o = 0; r_data_o = 0 while empty.
  - In-flight reads are dropped.
  - Memory contents are not reset and are preserved across reset.
  - gnt_o = 0 during the reset cycle.
- Out-of-range LATENCY, or MEM_WORDS not a power of two: elaboration error.

Test Plan:
1. LATENCY=1: write all 0xA5 bytes (be all 1) to 0x100, then read 0x100 with lrdy=1 → gnt in the grant cycle; r_valid exactly 1 cycle later; r_data all 0xA5; r_opc=0.
2. Partial write to 0x200 with be = 36'h0_0000_000F and data word0 = 0x11223344, after a prior full write of zeros → read word0 = 0x11223344; words 1..8 = 0.
3. LATENCY=3, FIFO_DEPTH=4, lrdy held 0, continuous reads to 0x0,0x24,0x48,... → exactly 4 grants, then gnt=0 and outstanding_o=4. Raising lrdy drains the responses in issue order, and grants resume the cycle after the first pop.
4. Wrap: MEM_WORDS=4096, write at byte address 0x3FF0 (widx 4092) → words 4092..4095 then 0..4 are written. A read at 0x0 shows the tail words.
5. Misaligned read at 0x102 with user=1 → data equals an aligned read at 0x100; r_opc=1; r_user=1.
6. Reset asserted with 2 reads in flight → no r_valid after reset, outstanding_o=0. A subsequent read of a previously written address returns the pre-reset data.

Source files
------------

// File: rtl/redmule_tcdm_responder_if.sv
// ---------------------------------------------------------------------------
// redmule_tcdm_responder_if
// Purpose : RedMulE wide TCDM data-port bundle between one initiator (master)
//           and the memory responder (slave).
// Signals : req/wen/be/add/data/lrdy/user  initiator -> memory
//           gnt/r_valid/r_data/r_opc/r_user memory -> initiator
//           wen = 1 selects a read, 0 a write; r_opc flags a misaligned read.
// ---------------------------------------------------------------------------
interface redmule_tcdm_responder_if #(
  parameter int unsigned DATA_W = 288,
  parameter int unsigned ADDR_W = 32
);
  logic                  req;
  logic                  wen;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     add;
  logic [DATA_W-1:0]     data;
  logic                  lrdy;
  logic                  user;
  logic                  gnt;
  logic                  r_valid;
  logic [DATA_W-1:0]     r_data;
  logic                  r_opc;
  logic                  r_user;

  modport master (
    output req, wen, be, add, data, lrdy, user,
    input  gnt, r_valid, r_data, r_opc, r_user
  );

  modport slave (
    input  req, wen, be, add, data, lrdy, user,
    output gnt, r_valid, r_data, r_opc, r_user
  );
endinterface

// File: rtl/redmule_tcdm_responder.sv
// ---------------------------------------------------------------------------
// redmule_tcdm_responder
// Purpose : Memory end of the RedMulE TCDM data port. Serves one DATA_W-bit
//           initiator from a word-interleaved array of 32-bit words with a
//           fixed read latency, credit-based grant back-pressure and a
//           response FIFO that honours lrdy.
// Ports   : clk_i          clock
//           rst_i          synchronous active-high reset (memory is kept)
//           stall_i        forced grant denial
//           tcdm           bus bundle (slave side)
//           outstanding_o  reads in the pipeline plus reads in the FIFO
// ---------------------------------------------------------------------------
module redmule_tcdm_responder #(
  parameter int unsigned       DATA_W     = 288,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       MEM_WORDS  = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       LATENCY    = 1,
  parameter int unsigned       FIFO_DEPTH = LATENCY + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          stall_i,
  redmule_tcdm_responder_if.slave       tcdm,
  output logic [$clog2(FIFO_DEPTH):0]   outstanding_o
);

  localparam int unsigned NW = DATA_W / 32;
  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned KW = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OW = $clog2(FIFO_DEPTH) + 1;
  // Response payload: {misalign, user, data}
  localparam int unsigned PL = DATA_W + 2;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("redmule_tcdm_responder: LATENCY must be in 1..4");
  end
  if (MEM_WORDS == 0 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_depth
    $error("redmule_tcdm_responder: MEM_WORDS must be a power of two");
  end
  if (DATA_W == 0 || (DATA_W % 32) != 0) begin : g_bad_width
    $error("redmule_tcdm_responder: DATA_W must be a multiple of 32");
  end
  if (MEM_WORDS < NW) begin : g_small_mem
    $error("redmule_tcdm_responder: MEM_WORDS must be >= DATA_W/32");
  end
  if (FIFO_DEPTH < 1) begin : g_bad_fifo
    $error("redmule_tcdm_responder: FIFO_DEPTH must be >= 1");
  end

  logic [AW-1:0]     w_widx;
  logic              w_misalign;
  logic              w_gnt;
  logic              w_rd_fire;
  logic              w_wr_fire;
  logic              w_nempty;
  logic              w_pop;
  logic [AW-1:0]     w_idx   [NW];
  logic [31:0]       w_wmask [NW];
  logic [31:0]       w_wdata [NW];
  logic [DATA_W-1:0] w_rd_data;
  logic [PL-1:0]     w_src;
  logic              w_push_v;
  logic [PL-1:0]     w_push_d;
  logic [PL-1:0]     w_head;

  logic [31:0]       r_mem  [MEM_WORDS];
  logic [PL-1:0]     r_fifo [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [PW:0]       r_cnt;
  logic [OW-1:0]     r_outst;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Truncation to AW bits implements the modulo-MEM_WORDS wrap; the two
  // low address bits are dropped, which aligns misaligned accesses down.
  always_comb begin
    w_widx     = AW'((tcdm.add - BASE_ADDR) >> 2);
    w_misalign = |tcdm.add[1:0];
    // Credits are only returned by a completed pop, never in the pop cycle.
    w_gnt      = ~rst_i & tcdm.req & ~stall_i &
                 (~tcdm.wen | (r_outst < OW'(FIFO_DEPTH)));
    w_rd_fire  = w_gnt & tcdm.wen;
    w_wr_fire  = w_gnt & ~tcdm.wen;
    w_nempty   = (r_cnt != '0);
    w_pop      = w_nempty & tcdm.lrdy;
    w_head     = r_fifo[r_rptr];
  end

  for (genvar k = 0; k < NW; k++) begin : g_word
    assign w_idx[k]               = w_widx + AW'(k);
    assign w_rd_data[32*k +: 32]  = r_mem[w_idx[k]];
    assign w_wdata[k]             = tcdm.data[32*k +: 32];
    for (genvar l = 0; l < 4; l++) begin : g_lane
      assign w_wmask[k][8*l +: 8] = {8{tcdm.be[4*k+l]}};
    end
  end

  // Memory contents are deliberately outside reset.
  always_ff @(posedge clk_i) begin
    if (w_wr_fire) begin
      for (int unsigned k = 0; k < NW; k++) begin
        r_mem[w_idx[k[KW-1:0]]] <= (r_mem[w_idx[k[KW-1:0]]] & ~w_wmask[k[KW-1:0]]) |
                                   (w_wdata[k[KW-1:0]] & w_wmask[k[KW-1:0]]);
      end
    end
  end

  assign w_src = {w_misalign, tcdm.user, w_rd_data};

  // The FIFO write is the last of the LATENCY stages, so only LATENCY-1
  // registers sit in front of it; with LATENCY=1 the grant-cycle memory
  // read is pushed directly.
  if (LATENCY == 1) begin : g_lat1
    assign w_push_v = w_rd_fire;
    assign w_push_d = w_src;
  end else begin : g_pipe
    localparam int unsigned NS = LATENCY - 1;
    localparam int unsigned SW = NS * PL;
    logic [NS-1:0]         r_v;
    logic [NS-1:0][PL-1:0] r_pd;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_v <= '0;
      end else begin
        r_v <= (r_v << 1) | NS'(w_rd_fire);
      end
      r_pd <= (r_pd << PL) | SW'(w_src);
    end

    assign w_push_v = r_v[NS-1];
    assign w_push_d = r_pd[NS-1];
  end

  always_ff @(posedge clk_i) begin
    if (w_push_v) begin
      r_fifo[r_wptr] <= w_push_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_outst <= '0;
    end else begin
      if (w_push_v) begin
        r_wptr <= f_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_inc(r_rptr);
      end
      case ({w_push_v, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      case ({w_rd_fire, w_pop})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
    end
  end

  always_comb begin
    tcdm.gnt      = w_gnt;
    tcdm.r_valid  = w_nempty;
    tcdm.r_data   = w_nempty ? w_head[DATA_W-1:0] : '0;
    tcdm.r_user   = w_nempty & w_head[DATA_W];
    tcdm.r_opc    = w_nempty & w_head[DATA_W+1];
    outstanding_o = r_outst;
  end

endmodule
